// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_pkg: AXI3 burst/response encodings and write-slave state enum.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_e;

  // AXI3 only permits wrapping bursts of 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_burst_addr_gen: next beat address for FIXED/INCR/WRAP bursts.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [3:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] bytes_w;
  logic [ADDR_W-1:0] wrap_bytes_w;
  logic [ADDR_W-1:0] len_ext_w;

  assign len_ext_w    = {{(ADDR_W-4){1'b0}}, len};
  assign bytes_w      = ADDR_W'(1) << size;
  assign wrap_bytes_w = (len_ext_w + ADDR_W'(1)) << size;

  always_comb begin
    next_addr = addr;
    case (burst)
      // INCR re-aligns an unaligned start address after the first beat.
      BURST_INCR: next_addr = (addr & ~(bytes_w - ADDR_W'(1))) + bytes_w;
      BURST_WRAP: next_addr = (addr & ~(wrap_bytes_w - ADDR_W'(1))) |
                              ((addr + bytes_w) & (wrap_bytes_w - ADDR_W'(1)));
      default:    next_addr = addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_wr_slave_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_wr_slave_burst: single-outstanding AXI3 write slave -> device.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axi_wr_slave_burst
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_W-1:0]       AWID,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ID_W-1:0]       WID,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_W-1:0]       BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [ADDR_W-1:0]     dev_addr,
  output logic [DATA_W-1:0]     dev_wdata,
  output logic [DATA_W/8-1:0]   dev_wstrb,
  output logic                  dev_wvalid,
  input  logic                  dev_wready
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [3:0]        count_q, count_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] next_addr_w;
  logic [ADDR_W-1:0] aw_align_mask_w;
  logic              aw_err_w;
  logic              beat_w;
  logic              last_beat_w;

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr_w)
  );

  assign aw_align_mask_w = (ADDR_W'(1) << AWSIZE) - ADDR_W'(1);
  assign aw_err_w = (AWSIZE > 3'(MAX_SIZE)) ||
                    (AWBURST == 2'b11) ||
                    ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN)) ||
                    ((AWBURST == BURST_WRAP) && ((AWADDR & aw_align_mask_w) != '0));

  assign last_beat_w = (count_q == len_q);
  assign dev_addr    = addr_q;
  assign dev_wdata   = WDATA;
  assign dev_wstrb   = WSTRB;
  assign BID         = id_q;
  assign BRESP       = ((state_q == RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    count_d    = count_q;
    err_d      = err_q;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BVALID     = 1'b0;
    dev_wvalid = 1'b0;
    beat_w     = 1'b0;

    case (state_q)
      IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) begin
          id_d    = AWID;
          addr_d  = AWADDR;
          len_d   = AWLEN;
          size_d  = AWSIZE;
          burst_d = AWBURST;
          count_d = 4'd0;
          err_d   = aw_err_w;
          state_d = DATA;
        end
      end

      DATA: begin
        // Once a burst is in error, remaining beats are swallowed, not written.
        if (err_q) begin
          WREADY = 1'b1;
          beat_w = WVALID;
        end else begin
          dev_wvalid = WVALID;
          WREADY     = dev_wready;
          beat_w     = WVALID && dev_wready;
        end

        if (beat_w) begin
          if (WID != id_q) begin
            err_d = 1'b1;
          end
          if (WLAST != last_beat_w) begin
            err_d = 1'b1;
          end
          count_d = count_q + 4'd1;
          addr_d  = next_addr_w;
          if (last_beat_w) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_wr_slave_burst: directed table-driven bench for the write     |
// | slave. Rev 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_axi_wr_slave_burst;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [3:0]  WID = '0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_wstrb;
  logic        dev_wvalid;
  logic        dev_wready = 1'b0;

  axi_wr_slave_burst #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_wstrb(dev_wstrb),
    .dev_wvalid(dev_wvalid), .dev_wready(dev_wready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic             stall;
    logic             bad_wid;
    logic [3:0]       wlast_beat;
    logic [3:0]       bwait;
    logic [3:0]       exp_writes;
    logic [3:0][31:0] exp_addr;
    logic [1:0]       exp_resp;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] id, input logic stall,
                              input logic bad_wid, input logic [3:0] wlast_beat,
                              input logic [3:0] bwait, input logic [3:0] exp_writes,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [1:0] exp_resp);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.stall = stall; v.bad_wid = bad_wid; v.wlast_beat = wlast_beat;
    v.bwait = bwait; v.exp_writes = exp_writes;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    v.exp_resp = exp_resp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Runs one burst from vecs[k]; entered and left just after a rising edge.
  task automatic run_burst(input int k);
    vec_t v;
    int beat, writes, cyc;
    v = vecs[k];
    AWID = v.id; AWADDR = v.addr; AWLEN = v.len; AWSIZE = v.size;
    AWBURST = v.burst; AWVALID = 1'b1; dev_wready = 1'b1;
    @(negedge ACLK);
    chk($sformatf("v%0d awready", k), 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    beat = 0; writes = 0; cyc = 0;
    while (beat <= int'(v.len) && cyc < 64) begin
      WVALID = 1'b1;
      WDATA  = 32'hA000_0000 + 32'(beat);
      WSTRB  = 4'hF;
      WLAST  = (beat == int'(v.wlast_beat));
      WID    = (v.bad_wid && beat == 0) ? ~v.id : v.id;
      dev_wready = v.stall ? (cyc % 2 == 0) : 1'b1;
      @(negedge ACLK);
      if (dev_wvalid && dev_wready) begin
        if (writes < 4)
          chk($sformatf("v%0d dev_addr[%0d]", k, writes), dev_addr, v.exp_addr[writes]);
        chk($sformatf("v%0d dev_wdata[%0d]", k, writes), dev_wdata, 32'hA000_0000 + 32'(beat));
        writes++;
      end
      if (WREADY) beat++;
      @(posedge ACLK); #1;
      cyc++;
    end
    WVALID = 1'b0; WLAST = 1'b0; dev_wready = 1'b0;
    chk($sformatf("v%0d beats_consumed", k), 32'(beat), 32'(v.len) + 32'd1);
    chk($sformatf("v%0d dev_writes", k), 32'(writes), 32'(v.exp_writes));
    chk($sformatf("v%0d beat_cycles", k), 32'(cyc),
        v.stall ? 32'(2 * int'(v.len) + 1) : 32'(v.len) + 32'd1);
    for (int j = 0; j < int'(v.bwait); j++) begin
      @(negedge ACLK);
      chk($sformatf("v%0d hold%0d bvalid", k, j), 32'(BVALID), 32'd1);
      chk($sformatf("v%0d hold%0d bresp", k, j), 32'(BRESP), 32'(v.exp_resp));
      chk($sformatf("v%0d hold%0d bid", k, j), 32'(BID), 32'(v.id));
      chk($sformatf("v%0d hold%0d awready", k, j), 32'(AWREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    chk($sformatf("v%0d bvalid", k), 32'(BVALID), 32'd1);
    chk($sformatf("v%0d bresp", k), 32'(BRESP), 32'(v.exp_resp));
    chk($sformatf("v%0d bid", k), 32'(BID), 32'(v.id));
    chk($sformatf("v%0d awready_in_resp", k), 32'(AWREADY), 32'd0);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk($sformatf("v%0d awready_after", k), 32'(AWREADY), 32'd1);
    chk($sformatf("v%0d bvalid_after", k), 32'(BVALID), 32'd0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    //         addr          len   sz    burst  id    stl  bwid wlb   bw    nw    a0/a1/a2/a3                                                  resp
    vecs[0]  = mk(32'h100,   4'd3, 3'd2, 2'b01, 4'd5, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 32'h100, 32'h104, 32'h108, 32'h10C, 2'b00);
    vecs[1]  = mk(32'h38,    4'd3, 3'd2, 2'b10, 4'd3, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 32'h38,  32'h3C,  32'h30,  32'h34,  2'b00);
    vecs[2]  = mk(32'h200,   4'd2, 3'd2, 2'b00, 4'd7, 1'b1, 1'b0, 4'd2, 4'd0, 4'd3, 32'h200, 32'h200, 32'h200, 32'h0,   2'b00);
    vecs[3]  = mk(32'h101,   4'd2, 3'd2, 2'b01, 4'd1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd3, 32'h101, 32'h104, 32'h108, 32'h0,   2'b00);
    vecs[4]  = mk(32'h22,    4'd1, 3'd1, 2'b10, 4'd2, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 32'h22,  32'h20,  32'h0,   32'h0,   2'b00);
    vecs[5]  = mk(32'h7,     4'd3, 3'd0, 2'b01, 4'd4, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 32'h7,   32'h8,   32'h9,   32'hA,   2'b00);
    vecs[6]  = mk(32'h0,     4'd1, 3'd3, 2'b01, 4'd6, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 32'h0,   32'h0,   32'h0,   32'h0,   2'b10);
    vecs[7]  = mk(32'h80,    4'd0, 3'd2, 2'b11, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0,   32'h0,   32'h0,   32'h0,   2'b10);
    vecs[8]  = mk(32'h40,    4'd2, 3'd2, 2'b10, 4'd3, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 32'h0,   32'h0,   32'h0,   32'h0,   2'b10);
    vecs[9]  = mk(32'h3A,    4'd3, 3'd2, 2'b10, 4'd1, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 32'h0,   32'h0,   32'h0,   32'h0,   2'b10);
    vecs[10] = mk(32'h100,   4'd3, 3'd2, 2'b01, 4'd9, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 32'h100, 32'h104, 32'h0,   32'h0,   2'b10);
    vecs[11] = mk(32'h40,    4'd1, 3'd2, 2'b01, 4'd5, 1'b0, 1'b1, 4'd1, 4'd0, 4'd1, 32'h40,  32'h0,   32'h0,   32'h0,   2'b10);
    vecs[12] = mk(32'h300,   4'd0, 3'd2, 2'b01, 4'd9, 1'b0, 1'b0, 4'd0, 4'd5, 4'd1, 32'h300, 32'h0,   32'h0,   32'h0,   2'b00);
    vecs[13] = mk(32'hFFFFFFFC, 4'd1, 3'd2, 2'b01, 4'd12, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 2'b00);

    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("reset awready", 32'(AWREADY), 32'd1);
    chk("reset wready", 32'(WREADY), 32'd0);
    chk("reset bvalid", 32'(BVALID), 32'd0);
    chk("reset bresp", 32'(BRESP), 32'd0);
    chk("reset bid", 32'(BID), 32'd0);
    chk("reset dev_wvalid", 32'(dev_wvalid), 32'd0);
    chk("reset dev_addr", dev_addr, 32'd0);
    @(posedge ACLK); #1;

    // Write data offered before any address must not be taken.
    WVALID = 1'b1; WLAST = 1'b1; dev_wready = 1'b1;
    @(negedge ACLK);
    chk("early_w wready", 32'(WREADY), 32'd0);
    chk("early_w dev_wvalid", 32'(dev_wvalid), 32'd0);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;

    for (int k = 0; k < NVEC; k++) run_burst(k);

    // Reset during beat 2 of an 8-beat burst.
    AWID = 4'd8; AWADDR = 32'h500; AWLEN = 4'd7; AWSIZE = 3'd2; AWBURST = 2'b01;
    AWVALID = 1'b1; dev_wready = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WVALID = 1'b1; WID = 4'd8; WDATA = 32'(b); WSTRB = 4'hF; WLAST = 1'b0;
      @(posedge ACLK); #1;
    end
    @(negedge ACLK);
    chk("midrst dev_addr_beat2", dev_addr, 32'h508);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("midrst awready", 32'(AWREADY), 32'd1);
    chk("midrst wready", 32'(WREADY), 32'd0);
    chk("midrst bvalid", 32'(BVALID), 32'd0);
    chk("midrst dev_wvalid", 32'(dev_wvalid), 32'd0);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    run_burst(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_wr_slave_burst.md
# axi_wr_slave_burst

Parametrised AXI3 write-channel slave that accepts one write burst at a time and streams its beats to a simple memory-side device port with a valid/ready handshake. Supports FIXED, INCR and WRAP bursts, narrow transfers, per-beat byte strobes, ID echo and error responses. It sits between the interconnect write channels and a device or memory controller, and replaces the fixed-width single-mode write slave.

## Interface
- DATA_W, 32: data bus width in bits; one of 32, 64 or 128.
- ADDR_W, 32: address width.
- ID_W, 4: AWID/WID/BID width.
- ACLK  in  1  clock.
- ARESETn  in  1  synchronous reset, active-low.
- AWID  in  ID_W; AWADDR  in  ADDR_W; AWLEN  in  4; AWSIZE  in  3; AWBURST  in  2: address-channel payload.
- AWVALID  in  1; AWREADY  out  1: address handshake.
- WID  in  ID_W; WDATA  in  DATA_W; WSTRB  in  DATA_W/8; WLAST  in  1; WVALID  in  1; WREADY  out  1: write-data channel.
- BID  out  ID_W; BRESP  out  2; BVALID  out  1; BREADY  in  1: write-response channel.
- dev_addr  out  ADDR_W: current beat address.
- dev_wdata  out  DATA_W; dev_wstrb  out  DATA_W/8: beat data and strobes (direct from WDATA/WSTRB).
- dev_wvalid  out  1; dev_wready  in  1: device beat handshake.

## Operation
- State IDLE: AWREADY=1. On AWVALID&&AWREADY, latch ID, address, len, size and burst; clear beat counter and error flag; go to DATA.
- Error detection at AW accept:
  - AWSIZE > log2(DATA_W/8), or AWBURST==2'b11, or WRAP with AWLEN not in {1,3,7,15}, or WRAP with AWADDR not size-aligned: set err.
- State DATA, err==0: dev_wvalid=WVALID, WREADY=dev_wready. Beat transfers when WVALID&&dev_wready.
- State DATA, err==1: dev_wvalid=0, WREADY=1. Beats are drained and not written.
- Per transferred beat:
  - If WID differs from the latched ID, set err; that beat is still written.
  - If WLAST != (count==len), set err.
  - Increment count and advance the address.
- Address update:
  - FIXED: unchanged.
  - INCR: (addr & ~(bytes-1)) + bytes, where bytes = 1<<size.
  - WRAP: wb = (len+1)<<size; next = (addr & ~(wb-1)) | ((addr+bytes) & (wb-1)).
- After the beat with count==len, go to RESP. Termination is by beat count, never by WLAST.
- State RESP: BVALID=1, BID=latched ID, BRESP=2'b10 (SLVERR) if err else 2'b00 (OKAY). On BREADY, go to IDLE.

## Timing
- Reset values: state IDLE, AWREADY=1, WREADY=0, BVALID=0, BRESP=0, BID=0, dev_wvalid=0, dev_addr=0, count=0, err=0.
- AW handshake in cycle T: the first beat can transfer in cycle T+1.
- Throughput is one beat per cycle while WVALID&&dev_wready.
- Last beat in cycle L: BVALID=1 from L+1 and is held stable until BREADY.
- BREADY sampled high in cycle R: AWREADY=1 in R+1. Minimum burst occupancy is len+3 cycles.
- AWREADY=0 outside IDLE; a second burst waits.
- WVALID arriving before the AW handshake is not accepted (WREADY=0 in IDLE).
- dev_addr is registered and valid in the same cycle as dev_wvalid.
- dev_wready may be high without WVALID; no transfer occurs and no state changes.
- Reset mid-burst: return to IDLE next edge; BVALID, dev_wvalid and WREADY are 0 after that edge; the partial burst receives no response.
- Address arithmetic is modulo 2^ADDR_W. INCR crossing a 4 KB boundary is not checked.

## Structure
- Package axi_pkg:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response encodings RESP_OKAY/SLVERR;
  - state enum IDLE/DATA/RESP.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, size, len, burst), parametrised by ADDR_W. Reusable by the read-side successor.

## Test plan
- INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, DATA_W=32, dev_wready=1 -> dev_addr 0x100,0x104,0x108,0x10C on consecutive cycles; BRESP=OKAY; BID=AWID.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> dev_addr 0x38,0x3C,0x30,0x34; OKAY.
- FIXED, AWLEN=2, dev_wready toggling 1/0 -> exactly 3 device writes, all at AWADDR; WDATA held on stalled cycles; OKAY.
- AWSIZE=3 on DATA_W=32, AWLEN=1 -> 2 beats accepted with WREADY=1, dev_wvalid never 1, BRESP=SLVERR.
- AWLEN=3 with WLAST asserted on beat 1 -> 4 beats still consumed, BRESP=SLVERR. Separately, BREADY held low for 5 cycles -> BVALID/BID/BRESP stable for 5 cycles, AWREADY=0.
- ARESETn low during beat 2 of AWLEN=7 -> next cycle state IDLE, AWREADY=1, WREADY=0, BVALID=0; a new burst then completes with OKAY.
